// File: rtl/axi4_burst_master_if.sv
// rtl/axi4_burst_master_if.sv - AXI4 read/write channel bundle for the burst master
interface axi4_burst_master_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - AXI4 master issuing INCR read bursts and single-beat writes
module axi4_burst_master #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    output logic        resp_last,
    output logic [63:0] resp_rdata,
    output logic        resp_wdone,
    output logic        resp_err,
    axi4_burst_master_if.master axi
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_RD   = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic [7:0]  beat_cnt;
    logic        err_acc;
    logic        aw_done;
    logic        w_done;

    logic        accept;
    logic        ar_hs;
    logic        r_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        last_exp;
    logic        rd_end;
    logic        beat_err;
    logic        b_err;

    assign accept   = (state == S_IDLE) && req_valid;
    assign ar_hs    = axi.arvalid && axi.arready;
    assign r_hs     = axi.rvalid && axi.rready;
    assign aw_hs    = axi.awvalid && axi.awready;
    assign w_hs     = axi.wvalid && axi.wready;
    assign b_hs     = axi.bvalid && axi.bready;
    // The beat counter only reaches len_q on the final beat, so len 255 never wraps early.
    assign last_exp = (beat_cnt == len_q);
    // An early rlast terminates the burst too; the rlast mismatch flags it as an error.
    assign rd_end   = r_hs && (axi.rlast || last_exp);
    assign beat_err = (axi.rresp != 2'b00) || (axi.rid != AXI_ID) || (axi.rlast != last_exp);
    assign b_err    = (axi.bresp != 2'b00) || (axi.bid != AXI_ID);

    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = 3'd3;
    assign axi.arburst = 2'b01;
    assign axi.arid    = AXI_ID;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;

    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'd3;
    assign axi.awburst = 2'b01;
    assign axi.awid    = AXI_ID;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;

    assign axi.wid     = AXI_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection from the current state and channel handshakes.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_valid) state_nx = req_write ? S_AW_W : S_AR;
            S_AR:   if (ar_hs) state_nx = S_RD;
            S_RD:   if (rd_end) state_nx = S_IDLE;
            S_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = S_B;
            S_B:    if (b_hs) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; AW and W each drop once their own beat is taken.
    always_comb begin
        req_ready   = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        case (state)
            S_IDLE: req_ready   = 1'b1;
            S_AR:   axi.arvalid = 1'b1;
            S_RD:   axi.rready  = 1'b1;
            S_AW_W: begin
                axi.awvalid = !aw_done;
                axi.wvalid  = !w_done;
            end
            S_B:    axi.bready  = 1'b1;
            default: req_ready  = 1'b0;
        endcase
    end

    // Request capture and per-transaction bookkeeping (beat count, sticky error, AW/W done).
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q   <= 32'd0;
            len_q    <= 8'd0;
            wdata_q  <= 64'd0;
            wstrb_q  <= 8'd0;
            beat_cnt <= 8'd0;
            err_acc  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            len_q    <= req_len;
            wdata_q  <= req_wdata;
            wstrb_q  <= req_wstrb;
            beat_cnt <= 8'd0;
            err_acc  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                err_acc  <= err_acc | beat_err;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Client responses, registered one cycle after the AXI beat that produced them.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            resp_rdata <= 64'd0;
            resp_wdone <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= r_hs;
            resp_last  <= rd_end;
            resp_wdone <= b_hs;
            if (r_hs) resp_rdata <= axi.rdata;
            if (rd_end) begin
                resp_err <= err_acc | beat_err;
            end else if (b_hs) begin
                resp_err <= b_err;
            end else begin
                resp_err <= 1'b0;
            end
        end
    end

endmodule
